conv_window_gen_3x3: RTL and testbench

- Streaming 3x3 window generator; sits directly upstream of the 3x3 convolution core.
- Accepts one FP32 pixel per valid cycle in raster order and buffers the two previous image rows.
- Presents the nine window taps as parallel words with a single valid strobe, ready for direct connection to the core's nine data inputs.
- Produces "valid" windows only (no padding): (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.

---
 rtl/conv_window_gen_3x3.sv | 124 ++++++++++++
 tb/tb_conv_window_gen_3x3.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen_3x3.sv
// Streaming 3x3 window generator: buffers two image rows and emits registered 3x3 taps.
// Optional macro CONV_WINDOW_STRIDE2_EN emits only windows whose top-left has even row and column.
module conv_window_gen_3x3 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  output logic [DATA_WIDTH-1:0] Data_Out0,
  output logic [DATA_WIDTH-1:0] Data_Out1,
  output logic [DATA_WIDTH-1:0] Data_Out2,
  output logic [DATA_WIDTH-1:0] Data_Out3,
  output logic [DATA_WIDTH-1:0] Data_Out4,
  output logic [DATA_WIDTH-1:0] Data_Out5,
  output logic [DATA_WIDTH-1:0] Data_Out6,
  output logic [DATA_WIDTH-1:0] Data_Out7,
  output logic [DATA_WIDTH-1:0] Data_Out8,
  output logic                  Valid_Out,
  output logic                  Frame_Done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] line2 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win      [9];
  logic [DATA_WIDTH-1:0] win_next [9];
  logic [DATA_WIDTH-1:0] taps     [9];
  logic                  col_last, row_last, frame_last, stride_ok, emit;

  assign col_last   = (col == COL_LAST);
  assign row_last   = (row == ROW_LAST);
  assign frame_last = col_last && row_last;

`ifdef CONV_WINDOW_STRIDE2_EN
  assign stride_ok = ~row[0] & ~col[0];
`else
  assign stride_ok = 1'b1;
`endif

  // S_RUN already implies row >= 2, so only the column needs checking
  assign emit = Valid_In && (state == S_RUN) && (col >= CW'(2)) && stride_ok;

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (Valid_In) state_next = S_FILL;
      S_FILL:  if (Valid_In && (row == RW'(1)) && col_last) state_next = S_RUN;
      S_RUN:   if (Valid_In && frame_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 9; i++) win_next[i] = win[i];
    for (int r = 0; r < 3; r++) begin
      win_next[3*r]   = win[3*r+1];
      win_next[3*r+1] = win[3*r+2];
    end
    win_next[2] = line2[col];
    win_next[5] = line1[col];
    win_next[8] = Data_In;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win[i]  <= '0;
        taps[i] <= '0;
      end
    end else begin
      state      <= state_next;
      Valid_Out  <= emit;
      Frame_Done <= Valid_In && frame_last;
      if (Valid_In) begin
        for (int i = 0; i < 9; i++) win[i] <= win_next[i];
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // Output taps only change on an emitted window so they hold across gaps
      if (emit) begin
        for (int i = 0; i < 9; i++) taps[i] <= win_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Valid_In) begin
      line2[col] <= line1[col];
      line1[col] <= Data_In;
    end
  end

  assign Data_Out0 = taps[0];
  assign Data_Out1 = taps[1];
  assign Data_Out2 = taps[2];
  assign Data_Out3 = taps[3];
  assign Data_Out4 = taps[4];
  assign Data_Out5 = taps[5];
  assign Data_Out6 = taps[6];
  assign Data_Out7 = taps[7];
  assign Data_Out8 = taps[8];

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Bench for conv_window_gen_3x3: a 4x4 and a 5x3 instance share one stream and are checked
// every cycle against a frame-image model, plus literal window expectations.
module tb_conv_window_gen_3x3;

  localparam int W0 = 4, H0 = 4, W1 = 5, H1 = 3;

  typedef struct packed {
    logic             fd;
    logic [8:0][31:0] t;
  } win_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        vin;
  logic [31:0] q0 [9];
  logic [31:0] q1 [9];
  logic        v0, v1, fd0, fd1;

  int checks = 0;
  int failures = 0;

  logic [31:0] img [2][4][5];
  int          pos [2];
  logic [31:0] exp_tap [2][9];
  logic        exp_v [2];
  logic        exp_fd [2];
  win_t        wq0 [$];
  win_t        wq1 [$];

  always #5 clk = ~clk;

  conv_window_gen_3x3 #(.DATA_WIDTH(32), .IMG_WIDTH(W0), .IMG_HEIGHT(H0)) dut (
    .clk(clk), .rst(rst), .Data_In(din), .Valid_In(vin),
    .Data_Out0(q0[0]), .Data_Out1(q0[1]), .Data_Out2(q0[2]),
    .Data_Out3(q0[3]), .Data_Out4(q0[4]), .Data_Out5(q0[5]),
    .Data_Out6(q0[6]), .Data_Out7(q0[7]), .Data_Out8(q0[8]),
    .Valid_Out(v0), .Frame_Done(fd0));

  conv_window_gen_3x3 #(.DATA_WIDTH(32), .IMG_WIDTH(W1), .IMG_HEIGHT(H1)) dut_b (
    .clk(clk), .rst(rst), .Data_In(din), .Valid_In(vin),
    .Data_Out0(q1[0]), .Data_Out1(q1[1]), .Data_Out2(q1[2]),
    .Data_Out3(q1[3]), .Data_Out4(q1[4]), .Data_Out5(q1[5]),
    .Data_Out6(q1[6]), .Data_Out7(q1[7]), .Data_Out8(q1[8]),
    .Valid_Out(v1), .Frame_Done(fd1));

  function automatic logic [31:0] fp32(input int n);
    int          e = 0;
    logic [7:0]  ex;
    logic [22:0] m;
    while ((n >> (e + 1)) != 0) e++;
    ex = 8'(127 + e);
    m  = 23'((n - (1 << e)) << (23 - e));
    return {1'b0, ex, m};
  endfunction

  function automatic bit stride_ok(input int r, input int c);
`ifdef CONV_WINDOW_STRIDE2_EN
    return ((r % 2) == 0) && ((c % 2) == 0);
`else
    return (r >= 0) && (c >= 0);
`endif
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: remember every pixel of the current frame; a window is the 3x3 block ending at it
  task automatic model_step(input int k, input int w, input int h);
    int   r, c;
    win_t wn;
    exp_v[k]  = 1'b0;
    exp_fd[k] = 1'b0;
    if (!rst) begin
      pos[k] = 0;
      for (int i = 0; i < 9; i++) exp_tap[k][i] = '0;
    end else if (vin) begin
      r = pos[k] / w;
      c = pos[k] % w;
      img[k][r][c] = din;
      if (r >= 2 && c >= 2 && stride_ok(r, c)) begin
        exp_v[k] = 1'b1;
        for (int i = 0; i < 9; i++) exp_tap[k][i] = img[k][r-2+i/3][c-2+i%3];
      end
      if (pos[k] == w * h - 1) begin
        exp_fd[k] = 1'b1;
        pos[k] = 0;
      end else begin
        pos[k]++;
      end
      if (exp_v[k]) begin
        wn.fd = exp_fd[k];
        for (int i = 0; i < 9; i++) wn.t[i] = exp_tap[k][i];
        if (k == 0) wq0.push_back(wn);
        else        wq1.push_back(wn);
      end
    end
  endtask

  task automatic compare(input int k, input logic v, input logic fd, input logic [31:0] t [9]);
    check_output($sformatf("valid_out%0d", k), {31'b0, v}, {31'b0, exp_v[k]});
    check_output($sformatf("frame_done%0d", k), {31'b0, fd}, {31'b0, exp_fd[k]});
    for (int i = 0; i < 9; i++)
      check_output($sformatf("tap%0d_%0d", k, i), t[i], exp_tap[k][i]);
  endtask

  always begin
    @(posedge clk);
    model_step(0, W0, H0);
    model_step(1, W1, H1);
    #2;
    compare(0, v0, fd0, q0);
    compare(1, v1, fd1, q1);
  end

  task automatic send(input logic [31:0] d, input logic v);
    @(negedge clk);
    din = d;
    vin = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(32'h0, 1'b0);
  endtask

  task automatic apply_stimulus(input int first, input int last, input bit gapped);
    for (int n = first; n <= last; n++) begin
      send(fp32(n), 1'b1);
      if (gapped) send(32'hDEADBEEF, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    vin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wq0.delete();
    wq1.delete();
  endtask

  // Window whose top-left pixel value is tl, in an integer-valued image of the given width
  task automatic check_window(input string name, input win_t w, input int tl, input int width);
    for (int i = 0; i < 9; i++)
      check_output($sformatf("%s_tap%0d", name, i), w.t[i], fp32(tl + (i / 3) * width + (i % 3)));
  endtask

  task automatic check_basic_frame(input string name);
    int first_exp [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
`ifndef CONV_WINDOW_STRIDE2_EN
    check_output({name, "_count"}, wq0.size(), 4);
    for (int i = 0; i < 9; i++)
      check_output($sformatf("%s_first_tap%0d", name, i), wq0[0].t[i], fp32(first_exp[i]));
    check_output({name, "_first_fd"}, {31'b0, wq0[0].fd}, 32'd0);
    check_window({name, "_last"}, wq0[3], 6, 4);
    check_output({name, "_last_fd"}, {31'b0, wq0[3].fd}, 32'd1);
`else
    check_output({name, "_count"}, wq0.size(), 1);
    for (int i = 0; i < 9; i++)
      check_output($sformatf("%s_first_tap%0d", name, i), wq0[0].t[i], fp32(first_exp[i]));
`endif
  endtask

  initial begin
    rst = 1'b0;
    din = '0;
    vin = 1'b0;
    pos[0] = 0;
    pos[1] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Basic frame 1..16; the 5x3 instance sees 1..15 as its own frame
    apply_stimulus(1, 16, 1'b0);
    idle(3);
    check_output("fp32_one", fp32(1), 32'h3f800000);
    check_output("first_tap0_lit", wq0[0].t[0], 32'h3f800000);
    check_output("first_tap8_lit", wq0[0].t[8], 32'h41300000);
    check_basic_frame("basic");
`ifndef CONV_WINDOW_STRIDE2_EN
    check_output("rowb_count", wq1.size(), 3);
    for (int j = 0; j < 3; j++)
      check_window($sformatf("rowb_w%0d", j), wq1[j], j + 1, 5);
    check_output("rowb_fd", {31'b0, wq1[2].fd}, 32'd1);
`else
    check_output("rowb_count", wq1.size(), 2);
`endif

    do_reset();
    apply_stimulus(1, 16, 1'b1);
    idle(3);
    check_basic_frame("gapped");

    do_reset();
    apply_stimulus(1, 32, 1'b0);
    idle(3);
`ifndef CONV_WINDOW_STRIDE2_EN
    check_output("b2b_count", wq0.size(), 8);
    check_window("b2b_f2_first", wq0[4], 17, 4);
    check_output("b2b_f1_fd", {31'b0, wq0[3].fd}, 32'd1);
    check_output("b2b_f2_fd", {31'b0, wq0[7].fd}, 32'd1);
`else
    check_output("b2b_count", wq0.size(), 2);
    check_window("b2b_f2_first", wq0[1], 17, 4);
`endif

    do_reset();
    apply_stimulus(1, 7, 1'b0);
    do_reset();
    apply_stimulus(1, 16, 1'b0);
    idle(3);
    check_basic_frame("midreset");

    do_reset();
    for (int n = 0; n < 4000; n++) begin
      send($urandom, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
      if (n == 2111) do_reset();
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
